// File: rtl/divider_arbiter.sv
// divider_arbiter: two-client round-robin front end for one shared bit-serial divider.
// Completes the divider's four-phase Req/Done handshake and answers divide-by-zero locally.
`default_nettype none

module divider_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] b1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero,
  output logic         grant,
  output logic         busy,
  output logic         div_req,
  output logic [N-1:0] div_a,
  output logic [N-1:0] div_b,
  input  logic         div_done,
  input  logic [N-1:0] div_quotient,
  input  logic [N-1:0] div_remainder
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DROP    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t       state, state_n;
  logic         last_grant, last_grant_n;
  logic         done0_n, done1_n, div_zero_n, grant_n, busy_n, div_req_n;
  logic [N-1:0] quotient_n, remainder_n, div_a_n, div_b_n;

  logic         sel;
  logic [N-1:0] sel_a, sel_b;
  logic         req_g;

  // On a tie the client that did not win last time goes first.
  assign sel   = (req0 && req1) ? ~last_grant : req1;
  assign sel_a = sel ? a1 : a0;
  assign sel_b = sel ? b1 : b0;
  assign req_g = grant ? req1 : req0;

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    done0_n      = done0;
    done1_n      = done1;
    quotient_n   = quotient;
    remainder_n  = remainder;
    div_zero_n   = div_zero;
    grant_n      = grant;
    div_req_n    = div_req;
    div_a_n      = div_a;
    div_b_n      = div_b;

    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_n = sel;
          div_a_n = sel_a;
          div_b_n = sel_b;
          if (sel_b == '0) begin
            quotient_n  = '1;
            remainder_n = sel_a;
            div_zero_n  = 1'b1;
            done0_n     = ~sel;
            done1_n     = sel;
            state_n     = RESPOND;
          end else begin
            div_req_n  = 1'b1;
            div_zero_n = 1'b0;
            state_n    = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (div_done) begin
          quotient_n  = div_quotient;
          remainder_n = div_remainder;
          div_req_n   = 1'b0;
          state_n     = DROP;
        end
      end

      // The client is only answered once the divider has released DivDone.
      DROP: begin
        if (!div_done) begin
          done0_n = ~grant;
          done1_n = grant;
          state_n = RESPOND;
        end
      end

      RESPOND: begin
        if (!req_g) begin
          done0_n      = 1'b0;
          done1_n      = 1'b0;
          last_grant_n = grant;
          state_n      = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      done0      <= 1'b0;
      done1      <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
      grant      <= 1'b0;
      busy       <= 1'b0;
      div_req    <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      done0      <= done0_n;
      done1      <= done1_n;
      quotient   <= quotient_n;
      remainder  <= remainder_n;
      div_zero   <= div_zero_n;
      grant      <= grant_n;
      busy       <= busy_n;
      div_req    <= div_req_n;
      div_a      <= div_a_n;
      div_b      <= div_b_n;
    end
  end

endmodule

`default_nettype wire
